// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the fulladd response checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } chk_state_e;

  // Legal LATENCY range is 0..MaxLatency.
  localparam int unsigned MaxLatency = 8;

  // Widest operand golden_add accepts; callers zero-extend and slice.
  localparam int unsigned GoldW = 32;

  function automatic logic [GoldW:0] golden_add(input logic [GoldW-1:0] a,
                                                input logic [GoldW-1:0] b,
                                                input logic             c_in);
    return {1'b0, a} + {1'b0, b} + {{GoldW{1'b0}}, c_in};
  endfunction

endpackage

// File: rtl/adder_checker_if.sv
// Stimulus, response and result bundle between the bench/wrapper and adder_checker.
interface adder_checker_if #(
  parameter int unsigned width = 2,
  parameter int unsigned CNT_W = 16
);

  logic               start;
  logic               stop;
  logic               in_valid;
  logic [width:0]     a;
  logic [width:0]     b;
  logic               c_in;
  logic [width:0]     dut_sum;
  logic               dut_c_out;
  logic               busy;
  logic               done;
  logic               error;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic [width+1:0]   fail_exp;
  logic [width+1:0]   fail_got;

  modport master (
    output start, stop, in_valid, a, b, c_in, dut_sum, dut_c_out,
    input  busy, done, error, pass_cnt, fail_cnt, fail_exp, fail_got
  );

  modport slave (
    input  start, stop, in_valid, a, b, c_in, dut_sum, dut_c_out,
    output busy, done, error, pass_cnt, fail_cnt, fail_exp, fail_got
  );

endinterface

// File: rtl/adder_chk_delay.sv
// Valid+data shift register aligning golden results to the adder pipeline.
module adder_chk_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned DataW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [DataW-1:0] out_data_o,
  output logic             empty_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, flush_i};
    assign out_valid_o = in_valid_i;
    assign out_data_o  = in_data_i;
    assign empty_o     = 1'b1;
  end else begin : g_shift
    logic [Depth-1:0] valid_q;
    logic [DataW-1:0] data_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        for (int i = 0; i < Depth; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid_i & ~flush_i;
        data_q[0]  <= in_data_i;
        for (int i = 1; i < Depth; i++) begin
          valid_q[i] <= valid_q[i-1] & ~flush_i;
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign out_valid_o = valid_q[Depth-1];
    assign out_data_o  = data_q[Depth-1];
    assign empty_o     = ~|valid_q;
  end

endmodule

// File: rtl/adder_checker.sv
// Response monitor for fulladd: golden compare, saturating pass/fail counts, first-miss capture.
module adder_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned width   = 2,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  adder_checker_if.slave bus
);

  localparam int unsigned ResW   = width + 2;
  localparam int unsigned DrainW = $clog2(MaxLatency + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(LATENCY);

  chk_state_e        state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
  logic              error_q, error_d;
  logic [ResW-1:0]   fexp_q, fexp_d, fgot_q, fgot_d;

  logic              clear, push, cmp_valid, empty;
  logic [ResW-1:0]   exp_in, cmp_exp, got;
  logic [GoldW:0]    gold_full;
  logic              unused_gold;

  assign gold_full   = golden_add(GoldW'(bus.a), GoldW'(bus.b), bus.c_in);
  assign exp_in      = gold_full[ResW-1:0];
  assign unused_gold = ^gold_full[GoldW:ResW];
  assign got         = {bus.dut_c_out, bus.dut_sum};
  assign push        = (state_q == StRun) & bus.in_valid;

  adder_chk_delay #(
    .Depth (LATENCY),
    .DataW (ResW)
  ) u_delay (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (clear),
    .in_valid_i  (push),
    .in_data_i   (exp_in),
    .out_valid_o (cmp_valid),
    .out_data_o  (cmp_exp),
    .empty_o     (empty)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clear       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // start outranks a simultaneous stop
        if (bus.start) begin
          state_d = StRun;
          clear   = 1'b1;
        end
      end
      StRun: begin
        if (bus.stop) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        // Fixed LATENCY+1 drain keeps done timing independent of traffic.
        if (drain_cnt_q == DrainLast && empty) state_d = StDone;
        else drain_cnt_d = drain_cnt_q + DrainW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pass_d  = pass_q;
    fail_d  = fail_q;
    error_d = error_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;
    if (clear) begin
      pass_d  = '0;
      fail_d  = '0;
      error_d = 1'b0;
      fexp_d  = '0;
      fgot_d  = '0;
    end else if (cmp_valid) begin
      if (got == cmp_exp) begin
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        error_d = 1'b1;
        if (!error_q) begin
          fexp_d = cmp_exp;
          fgot_d = got;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      error_q     <= 1'b0;
      fexp_q      <= '0;
      fgot_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      error_q     <= error_d;
      fexp_q      <= fexp_d;
      fgot_q      <= fgot_d;
    end
  end

  assign bus.busy     = (state_q == StRun) | (state_q == StDrain);
  assign bus.done     = (state_q == StDone);
  assign bus.error    = error_q;
  assign bus.pass_cnt = pass_q;
  assign bus.fail_cnt = fail_q;
  assign bus.fail_exp = fexp_q;
  assign bus.fail_got = fgot_q;

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker at LATENCY 1/4/0 and a 4-bit counter build, scoreboard-checked.
module tb_adder_checker;

  typedef struct {
    int due;
    int pass;
    int fail;
    bit err;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        start, stop, in_valid, c_in, fault;
  logic [2:0]  a, b;
  logic [3:0]  fault_word;
  logic [3:0]  resp_now;
  logic [3:0]  resp_pipe [8];
  logic [31:0] o_busy, o_done, o_error, o_pass, o_fail, o_fexp, o_fgot;

  int  cycle = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  m_pass, m_fail, m_fexp, m_fgot;
  bit  m_capt;
  sb_t sb[$];

  always #5 clk = ~clk;

  // Behavioural adder: optionally corrupted response, delayed per DUT latency.
  always_comb resp_now = fault ? fault_word : ({1'b0, a} + {1'b0, b} + {3'b000, c_in});
  always @(posedge clk) begin
    resp_pipe[0] <= resp_now;
    for (int i = 1; i < 8; i++) resp_pipe[i] <= resp_pipe[i-1];
  end

  adder_checker_if #(.width(2), .CNT_W(16)) if0 ();
  adder_checker_if #(.width(2), .CNT_W(16)) if1 ();
  adder_checker_if #(.width(2), .CNT_W(4))  if2 ();
  adder_checker_if #(.width(2), .CNT_W(16)) if3 ();

  assign if0.start = start & (sel == 0);
  assign if0.stop = stop & (sel == 0);
  assign if0.in_valid = in_valid & (sel == 0);
  assign if0.a = a;
  assign if0.b = b;
  assign if0.c_in = c_in;
  assign if0.dut_sum = resp_pipe[0][2:0];
  assign if0.dut_c_out = resp_pipe[0][3];

  assign if1.start = start & (sel == 1);
  assign if1.stop = stop & (sel == 1);
  assign if1.in_valid = in_valid & (sel == 1);
  assign if1.a = a;
  assign if1.b = b;
  assign if1.c_in = c_in;
  assign if1.dut_sum = resp_pipe[3][2:0];
  assign if1.dut_c_out = resp_pipe[3][3];

  assign if2.start = start & (sel == 2);
  assign if2.stop = stop & (sel == 2);
  assign if2.in_valid = in_valid & (sel == 2);
  assign if2.a = a;
  assign if2.b = b;
  assign if2.c_in = c_in;
  assign if2.dut_sum = resp_pipe[0][2:0];
  assign if2.dut_c_out = resp_pipe[0][3];

  assign if3.start = start & (sel == 3);
  assign if3.stop = stop & (sel == 3);
  assign if3.in_valid = in_valid & (sel == 3);
  assign if3.a = a;
  assign if3.b = b;
  assign if3.c_in = c_in;
  assign if3.dut_sum = resp_now[2:0];
  assign if3.dut_c_out = resp_now[3];

  adder_checker #(.width(2), .LATENCY(1), .CNT_W(16)) u_d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  adder_checker #(.width(2), .LATENCY(4), .CNT_W(16)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  adder_checker #(.width(2), .LATENCY(1), .CNT_W(4))  u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));
  adder_checker #(.width(2), .LATENCY(0), .CNT_W(16)) u_d3 (.clk(clk), .rst(rst), .bus(if3.slave));

  always_comb begin
    o_busy = '0; o_done = '0; o_error = '0; o_pass = '0; o_fail = '0; o_fexp = '0; o_fgot = '0;
    case (sel)
      0: begin
        o_busy = 32'(if0.busy); o_done = 32'(if0.done); o_error = 32'(if0.error);
        o_pass = 32'(if0.pass_cnt); o_fail = 32'(if0.fail_cnt);
        o_fexp = 32'(if0.fail_exp); o_fgot = 32'(if0.fail_got);
      end
      1: begin
        o_busy = 32'(if1.busy); o_done = 32'(if1.done); o_error = 32'(if1.error);
        o_pass = 32'(if1.pass_cnt); o_fail = 32'(if1.fail_cnt);
        o_fexp = 32'(if1.fail_exp); o_fgot = 32'(if1.fail_got);
      end
      2: begin
        o_busy = 32'(if2.busy); o_done = 32'(if2.done); o_error = 32'(if2.error);
        o_pass = 32'(if2.pass_cnt); o_fail = 32'(if2.fail_cnt);
        o_fexp = 32'(if2.fail_exp); o_fgot = 32'(if2.fail_got);
      end
      default: begin
        o_busy = 32'(if3.busy); o_done = 32'(if3.done); o_error = 32'(if3.error);
        o_pass = 32'(if3.pass_cnt); o_fail = 32'(if3.fail_cnt);
        o_fexp = 32'(if3.fail_exp); o_fgot = 32'(if3.fail_got);
      end
    endcase
  end

  function automatic int lat_of(int s);
    case (s)
      1:       return 4;
      3:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int max_of(int s);
    return (s == 2) ? 15 : 65535;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    cycle++;
    #1;
    while (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      check("sb_pass_cnt", o_pass, e.pass);
      check("sb_fail_cnt", o_fail, e.fail);
      check("sb_error", o_error, 32'(e.err));
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_error"}, o_error, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_fail"}, o_fail, 0);
    check({tag, "_fexp"}, o_fexp, 0);
    check({tag, "_fgot"}, o_fgot, 0);
  endtask

  task automatic send(int av, int bv, int cv, int flt = 0, int fw = 0, int counted = 1);
    int  g;
    bit  ok;
    g = av + bv + cv;
    a = 3'(av); b = 3'(bv); c_in = 1'(cv);
    fault = 1'(flt); fault_word = 4'(fw); in_valid = 1'b1;
    if (counted != 0) begin
      ok = (flt == 0) || (fw == g);
      if (ok) m_pass = (m_pass < max_of(sel)) ? m_pass + 1 : m_pass;
      else m_fail = (m_fail < max_of(sel)) ? m_fail + 1 : m_fail;
      if (!ok && !m_capt) begin
        m_capt = 1'b1; m_fexp = g; m_fgot = fw;
      end
      sb.push_back('{cycle + 1 + lat_of(sel), m_pass, m_fail, m_fail > 0});
    end
    tick();
    in_valid = 1'b0;
    fault = 1'b0;
  endtask

  task automatic start_run(bit with_stop);
    start = 1'b1; stop = with_stop;
    m_pass = 0; m_fail = 0; m_capt = 1'b0; m_fexp = 0; m_fgot = 0;
    sb.delete();
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_done", o_done, 0);
    check("start_pass", o_pass, 0);
    check("start_fail", o_fail, 0);
    check("start_error", o_error, 0);
  endtask

  task automatic wait_done(bit noise);
    int n;
    check("drain_busy", o_busy, 1);
    check("drain_not_done", o_done, 0);
    n = 0;
    while (o_done == 0 && n < 20) begin
      if (noise) begin
        a = 3'($urandom_range(7, 0)); b = 3'($urandom_range(7, 0)); in_valid = 1'b1;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("done_latency", n, lat_of(sel) + 1);
    check("sb_drained", sb.size(), 0);
    check("final_pass", o_pass, m_pass);
    check("final_fail", o_fail, m_fail);
    check("final_error", o_error, 32'(m_fail > 0));
    check("final_fexp", o_fexp, m_fexp);
    check("final_fgot", o_fgot, m_fgot);
  endtask

  task automatic finish_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(1'b0);
  endtask

  initial begin
    rst = 1'b0; sel = 0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; c_in = 1'b0; fault = 1'b0; fault_word = '0;
    #1 rst = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check_zero("reset");
    end
    tick();
    tick();
    rst = 1'b0;

    // Clean run, with a start pulse mid-run that must be ignored.
    sel = 0;
    start_run(1'b0);
    send(1, 2, 0);
    send(3, 5, 1);
    start = 1'b1;
    send(7, 0, 1);
    start = 1'b0;
    send(4, 4, 0);
    send(6, 6, 1);
    finish_run();
    check("clean_pass", o_pass, 5);
    check("clean_fail", o_fail, 0);
    check("clean_error", o_error, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_done", o_done, 1);
    check("stop_in_done_pass", o_pass, 5);

    // Fault capture: first miss is kept, second only counts.
    start_run(1'b0);
    send(3, 5, 1, 1, 1);
    send(1, 1, 0);
    send(2, 2, 0, 1, 0);
    finish_run();
    check("fault_fail", o_fail, 2);
    check("fault_error", o_error, 1);
    check("fault_exp", o_fexp, 'h9);
    check("fault_got", o_fgot, 'h1);

    // Drain at LATENCY=4 with traffic during DRAIN.
    sel = 1;
    start_run(1'b0);
    tick();
    tick();
    send(1, 1, 1);
    send(2, 3, 0);
    stop = 1'b1;
    send(5, 6, 1);
    stop = 1'b0;
    wait_done(1'b1);
    check("drain_pass", o_pass, 3);

    // Saturation with a 4-bit counter.
    sel = 2;
    start_run(1'b0);
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), int'($urandom_range(1, 0)));
    finish_run();
    check("sat_pass", o_pass, 15);
    check("sat_fail", o_fail, 0);

    // LATENCY=0 compares in the accept cycle.
    sel = 3;
    start_run(1'b0);
    send(2, 1, 1);
    send(7, 7, 0, 1, 3);
    send(0, 0, 0);
    finish_run();

    // Reset with two vectors in flight.
    sel = 1;
    start_run(1'b0);
    send(2, 2, 1);
    send(1, 0, 0, 1, 5);
    repeat (4) tick();
    send(3, 3, 0);
    send(4, 1, 1);
    rst = 1'b1;
    sb.delete();
    m_pass = 0; m_fail = 0; m_capt = 1'b0; m_fexp = 0; m_fgot = 0;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0;
    send(5, 5, 0, 0, 0, 0);
    send(1, 2, 1, 0, 0, 0);
    repeat (5) tick();
    check("idle_busy", o_busy, 0);
    check("idle_pass", o_pass, 0);
    check("idle_fail", o_fail, 0);
    start_run(1'b0);
    send(2, 5, 1);
    finish_run();
    check("rerun_pass", o_pass, 1);

    // Same-cycle start+stop from IDLE, and the full-width carry case.
    sel = 0;
    start_run(1'b1);
    send(7, 7, 1);
    send(7, 7, 1, 1, 0);
    finish_run();
    check("bnd_pass", o_pass, 1);
    check("bnd_fexp", o_fexp, 'hF);
    check("bnd_fgot", o_fgot, 'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
